gamma_sched: RTL and testbench

- Scheduler for an array of temporal-logic `equal` lanes.
- Accepts one command of per-lane operand spike times and clears the lane latches.
- Replays the operands as PULSE_WIDTH pulses across one gamma window of GAMMA_CYCLE_WIDTH ticks, then returns the first-spike time of each lane's output.
- Sits between the host-side command stream and the race-logic datapath; drives the datapath's `a`, `b` and latch-reset inputs.

---
 rtl/gamma_pkg.sv | 22 ++
 rtl/spike_lane.sv | 68 ++++++
 rtl/gamma_sched.sv | 131 +++++++++++++
 tb/tb_gamma_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gamma_pkg.sv
// Shared types and helpers for the gamma-window scheduler and its per-lane spike logic.
package gamma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StEval,
    StDone
  } state_e;

  // All-ones spike time encodes "no spike".
  function automatic int unsigned inf_time(input int unsigned tw);
    return (32'd1 << tw) - 32'd1;
  endfunction

  // Evaluated at 32 bits so start + width cannot wrap past the window.
  function automatic logic in_pulse(input int unsigned t, input int unsigned start,
                                    input int unsigned width, input int unsigned inf);
    return (start != inf) && (t >= start) && (t < start + width);
  endfunction

endpackage

// File: rtl/spike_lane.sv
// One scheduler lane: latched operand times, two registered pulse generators and the
// first-high capture of the datapath output.
module spike_lane
  import gamma_pkg::*;
#(
  parameter int unsigned TW         = 5,
  parameter int unsigned PulseWidth = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [TW-1:0] a_time_i,
  input  logic [TW-1:0] b_time_i,
  input  logic          eval_next_i,
  input  logic [TW-1:0] t_next_i,
  input  logic          eval_i,
  input  logic [TW-1:0] t_i,
  input  logic          res_i,
  output logic          spike_a_o,
  output logic          spike_b_o,
  output logic [TW-1:0] res_time_o
);

  localparam logic [TW-1:0] Inf = TW'(inf_time(TW));

  logic [TW-1:0] a_q, a_d;
  logic [TW-1:0] b_q, b_d;
  logic [TW-1:0] res_q, res_d;
  logic          spike_a_q, spike_a_d;
  logic          spike_b_q, spike_b_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    if (load_i) begin
      a_d   = a_time_i;
      b_d   = b_time_i;
      res_d = Inf;
    end else if (eval_i && res_i && (res_q == Inf)) begin
      res_d = t_i;
    end
    // Pulses are registered, so they are computed from the tick of the coming cycle.
    spike_a_d = eval_next_i && in_pulse(32'(t_next_i), 32'(a_q), PulseWidth, 32'(Inf));
    spike_b_d = eval_next_i && in_pulse(32'(t_next_i), 32'(b_q), PulseWidth, 32'(Inf));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q       <= Inf;
      b_q       <= Inf;
      res_q     <= '0;
      spike_a_q <= 1'b0;
      spike_b_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      spike_a_q <= spike_a_d;
      spike_b_q <= spike_b_d;
    end
  end

  assign spike_a_o  = spike_a_q;
  assign spike_b_o  = spike_b_q;
  assign res_time_o = res_q;

endmodule

// File: rtl/gamma_sched.sv
// Gamma-window scheduler: accepts a command, clears the lanes, replays the operand pulses
// for one window and returns the first-spike time of each lane.
module gamma_sched
  import gamma_pkg::*;
#(
  parameter int unsigned NUM_LANES         = 4,
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 8,
  parameter int unsigned CLEAR_CYCLES      = 2,
  parameter int unsigned T_W               = 5
) (
  input  logic                     aclk,
  input  logic                     grst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [NUM_LANES*T_W-1:0] cmd_a_time,
  input  logic [NUM_LANES*T_W-1:0] cmd_b_time,
  output logic [NUM_LANES-1:0]     spike_a,
  output logic [NUM_LANES-1:0]     spike_b,
  output logic                     gamma_clear,
  input  logic [NUM_LANES-1:0]     res_in,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [NUM_LANES*T_W-1:0] res_time,
  output logic                     busy
);

  localparam int unsigned CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0]  ClrLast = CW'(CLEAR_CYCLES - 1);
  localparam logic [T_W-1:0] TLast   = T_W'(GAMMA_CYCLE_WIDTH - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [T_W-1:0] t_q, t_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           gamma_clear_q, gamma_clear_d;
  logic           res_valid_q, res_valid_d;
  logic           busy_q, busy_d;
  logic           cmd_fire;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    t_d       = t_q;
    cmd_fire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d   = StClear;
          clr_cnt_d = '0;
          t_d       = '0;
          cmd_fire  = 1'b1;
        end
      end
      StClear: begin
        if (clr_cnt_q == ClrLast) begin
          state_d = StEval;
          t_d     = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
      end
      StEval: begin
        if (t_q == TLast) begin
          state_d = StDone;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Handshake/status outputs are registered from the next state.
    cmd_ready_d   = (state_d == StIdle);
    gamma_clear_d = (state_d == StClear);
    res_valid_d   = (state_d == StDone);
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge aclk) begin
    if (grst) begin
      state_q       <= StIdle;
      clr_cnt_q     <= '0;
      t_q           <= '0;
      cmd_ready_q   <= 1'b0;
      gamma_clear_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      t_q           <= t_d;
      cmd_ready_q   <= cmd_ready_d;
      gamma_clear_q <= gamma_clear_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign gamma_clear = gamma_clear_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    spike_lane #(
      .TW        (T_W),
      .PulseWidth(PULSE_WIDTH)
    ) u_lane (
      .clk_i      (aclk),
      .rst_i      (grst),
      .load_i     (cmd_fire),
      .a_time_i   (cmd_a_time[i*T_W +: T_W]),
      .b_time_i   (cmd_b_time[i*T_W +: T_W]),
      .eval_next_i(state_d == StEval),
      .t_next_i   (t_d),
      .eval_i     (state_q == StEval),
      .t_i        (t_q),
      .res_i      (res_in[i]),
      .spike_a_o  (spike_a[i]),
      .spike_b_o  (spike_b[i]),
      .res_time_o (res_time[i*T_W +: T_W])
    );
  end

endmodule

// File: tb/tb_gamma_sched.sv
// Directed bench for gamma_sched: vector table of commands plus hold, forced-input and
// mid-window reset sequences, with the datapath modelled as an "equal" gate per lane.
module tb_gamma_sched;

  localparam int N = 4;
  localparam int TW = 5;

  typedef struct packed {
    logic [N-1:0][TW-1:0] a;
    logic [N-1:0][TW-1:0] b;
    logic [N-1:0][TW-1:0] r;
  } vec_t;

  logic                 aclk = 1'b0;
  logic                 grst;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [N*TW-1:0]      cmd_a_time;
  logic [N*TW-1:0]      cmd_b_time;
  logic [N-1:0]         spike_a;
  logic [N-1:0]         spike_b;
  logic                 gamma_clear;
  logic [N-1:0]         res_in;
  logic                 res_valid;
  logic                 res_ready;
  logic [N*TW-1:0]      res_time;
  logic                 busy;

  logic [N-1:0][TW-1:0] cur_a;
  logic [N-1:0][TW-1:0] cur_b;
  logic                 force_en;
  logic                 force_val;

  int checks = 0;
  int errors = 0;

  gamma_sched dut (
    .aclk       (aclk),
    .grst       (grst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a_time (cmd_a_time),
    .cmd_b_time (cmd_b_time),
    .spike_a    (spike_a),
    .spike_b    (spike_b),
    .gamma_clear(gamma_clear),
    .res_in     (res_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_time   (res_time),
    .busy       (busy)
  );

  always #5 aclk = ~aclk;

  // Datapath model: an "equal" lane fires only while both pulses are up and the times match.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      res_in[i] = spike_a[i] & spike_b[i] & (cur_a[i] == cur_b[i]);
    end
    if (force_en) res_in[3] = force_val;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected pulse level in cycle k after the command handshake (EVAL is k = 3..18).
  function automatic logic exp_pulse(input int k, input logic [TW-1:0] tm);
    int t;
    t = k - 3;
    if (k < 3 || k > 18) return 1'b0;
    return (tm != 5'd31) && (t >= int'(tm)) && (t < int'(tm) + 8);
  endfunction

  // Entered and left at a negedge; on return the scheduler is idle again.
  task automatic run_cmd(input vec_t v, input int hold, input bit frc, input string tag);
    int lat;
    int serr;
    int cerr;
    int herr;
    logic [N*TW-1:0] snap;
    check({tag, " cmd_ready before"}, 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_a_time = v.a;
    cmd_b_time = v.b;
    cur_a      = v.a;
    cur_b      = v.b;
    res_ready  = (hold == 0);
    force_en   = frc;
    force_val  = 1'b0;
    @(negedge aclk);
    cmd_valid = 1'b0;
    lat  = 0;
    serr = 0;
    cerr = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (frc) force_val = (k == 1 || k == 2 || k == 10 || k == 12);
      for (int i = 0; i < N; i++) begin
        if (spike_a[i] !== exp_pulse(k, v.a[i])) serr++;
        if (spike_b[i] !== exp_pulse(k, v.b[i])) serr++;
      end
      if (gamma_clear !== (k == 1 || k == 2)) cerr++;
      if (res_valid === 1'b1) lat = k;
      else @(negedge aclk);
    end
    force_en = 1'b0;
    check({tag, " res_valid latency"}, 32'(lat), 32'd19);
    check({tag, " spike pattern errors"}, 32'(serr), 32'd0);
    check({tag, " gamma_clear pattern errors"}, 32'(cerr), 32'd0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s res_time[%0d]", tag, i), 32'(res_time[i*TW +: TW]), 32'(v.r[i]));
    end
    snap = res_time;
    herr = 0;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      @(negedge aclk);
      if (res_valid !== 1'b1 || res_time !== snap || cmd_ready !== 1'b0) herr++;
    end
    if (hold > 0) check({tag, " DONE hold errors"}, 32'(herr), 32'd0);
    res_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge aclk);
    check({tag, " res_valid after handshake"}, 32'(res_valid), 32'd0);
    check({tag, " cmd_ready after handshake"}, 32'(cmd_ready), 32'd1);
    check({tag, " busy after handshake"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[4];
  vec_t vf;

  initial begin
    // Lane order in concatenations is {lane3, lane2, lane1, lane0}.
    vecs[0] = '{a: {5'd31, 5'd31, 5'd31, 5'd3}, b: {5'd31, 5'd31, 5'd31, 5'd3},
                r: {5'd31, 5'd31, 5'd31, 5'd3}};
    vecs[1] = '{a: {5'd31, 5'd14, 5'd2, 5'd31}, b: {5'd31, 5'd14, 5'd5, 5'd31},
                r: {5'd31, 5'd14, 5'd31, 5'd31}};
    vecs[2] = '{a: {5'd4, 5'd16, 5'd15, 5'd0}, b: {5'd4, 5'd16, 5'd15, 5'd0},
                r: {5'd4, 5'd31, 5'd15, 5'd0}};
    vecs[3] = '{a: {5'd12, 5'd7, 5'd31, 5'd5}, b: {5'd12, 5'd7, 5'd6, 5'd5},
                r: {5'd12, 5'd7, 5'd31, 5'd5}};
    vf      = '{a: {5'd31, 5'd31, 5'd31, 5'd31}, b: {5'd31, 5'd31, 5'd31, 5'd31},
                r: {5'd7, 5'd31, 5'd31, 5'd31}};

    grst       = 1'b1;
    cmd_valid  = 1'b0;
    cmd_a_time = '0;
    cmd_b_time = '0;
    res_ready  = 1'b1;
    cur_a      = '1;
    cur_b      = '1;
    force_en   = 1'b0;
    force_val  = 1'b0;

    repeat (2) @(negedge aclk);
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset gamma_clear", 32'(gamma_clear), 32'd1);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset spikes", 32'({spike_a, spike_b}), 32'd0);
    check("reset res_time", 32'(res_time), 32'd0);
    grst = 1'b0;
    @(negedge aclk);
    check("post-reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("post-reset gamma_clear", 32'(gamma_clear), 32'd0);

    // Back-to-back commands with res_ready held high.
    for (int i = 0; i < 4; i++) run_cmd(vecs[i], 0, 1'b0, $sformatf("vec%0d", i));

    run_cmd(vecs[0], 10, 1'b0, "hold");
    run_cmd(vf, 0, 1'b1, "force");

    // Reset at EVAL tick 5 (cycle 8 after the handshake).
    cmd_valid  = 1'b1;
    cmd_a_time = vecs[0].a;
    cmd_b_time = vecs[0].b;
    cur_a      = vecs[0].a;
    cur_b      = vecs[0].b;
    @(negedge aclk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge aclk);
    check("midrst busy before", 32'(busy), 32'd1);
    grst = 1'b1;
    @(negedge aclk);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst spikes", 32'({spike_a, spike_b}), 32'd0);
    check("midrst gamma_clear", 32'(gamma_clear), 32'd1);
    check("midrst res_valid", 32'(res_valid), 32'd0);
    grst = 1'b0;
    @(negedge aclk);
    check("midrst release res_valid", 32'(res_valid), 32'd0);
    check("midrst release gamma_clear", 32'(gamma_clear), 32'd0);
    run_cmd(vecs[3], 0, 1'b0, "after-reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
